// File: rtl/gate_sweep_ctrl_if.sv
// Handshake, datapath drive/observe and result bus for gate_sweep_ctrl.
// slave  : the sweep controller (accepts start, drives the datapath and results).
// master : the environment (requests runs, hosts the AND/OR datapath).
interface gate_sweep_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] dut_in;
    logic       dut_out1;
    logic       dut_out2;
    logic [7:0] err_cnt;
    logic       first_fail_vld;
    logic [2:0] first_fail_vec;

    modport master (
        output start,
        output dut_out1,
        output dut_out2,
        input  busy,
        input  done,
        input  pass,
        input  dut_in,
        input  err_cnt,
        input  first_fail_vld,
        input  first_fail_vec
    );

    modport slave (
        input  start,
        input  dut_out1,
        input  dut_out2,
        output busy,
        output done,
        output pass,
        output dut_in,
        output err_cnt,
        output first_fail_vld,
        output first_fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Sweep controller for the three-input AND/OR datapath: drives all eight
// input vectors REPEAT times, samples both outputs after SETTLE_CYCLES extra
// cycles per vector, counts mismatches and reports pass/fail.
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN ends the run on the first
// mismatch instead of completing every sweep.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned REPEAT        = 1
) (
    input  logic             clk,
    input  logic             rst,
    gate_sweep_ctrl_if.slave io_sweep
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 3;
    localparam int unsigned ERR_W = 8;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(REPEAT - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = '1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_sweep;
    logic [CNT_W-1:0]   r_settle;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [VEC_W-1:0]   r_dut_in;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_ff_vld;
    logic [VEC_W-1:0]   r_ff_vec;

    logic               w_exp1;
    logic               w_exp2;
    logic               w_sample;
    logic               w_mismatch;
    logic               w_last_cmp;
    logic               w_end_run;
    logic [VEC_W-1:0]   w_vec_next;
    logic [ERR_W-1:0]   w_err_next;

    // Expected gate outputs and compare strobe for the vector being held
    assign w_exp1     = &r_vec;
    assign w_exp2     = |r_vec;
    assign w_sample   = (r_state == ST_RUN) && (r_settle == SETTLE_LAST);
    assign w_mismatch = w_sample &&
                        ((io_sweep.dut_out1 != w_exp1) || (io_sweep.dut_out2 != w_exp2));
    assign w_last_cmp = w_sample && (r_vec == VEC_LAST) && (r_sweep == SWEEP_LAST);
    assign w_end_run  = w_last_cmp || (STOP_ON_FAIL && w_mismatch);
    assign w_vec_next = r_vec + VEC_W'(1);
    assign w_err_next = (w_mismatch && (r_err_cnt != ERR_MAX)) ? r_err_cnt + ERR_W'(1)
                                                                : r_err_cnt;

    // Run FSM with vector/sweep/settle counters and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= '0;
            r_sweep   <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_dut_in  <= '0;
            r_err_cnt <= '0;
            r_ff_vld  <= 1'b0;
            r_ff_vec  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done   <= 1'b0;
                    r_dut_in <= '0;
                    if (io_sweep.start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_err_cnt <= '0;
                        r_ff_vld  <= 1'b0;
                        r_ff_vec  <= '0;
                        r_vec     <= '0;
                        r_sweep   <= '0;
                        r_settle  <= '0;
                    end
                end

                ST_RUN: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && !r_ff_vld) begin
                            r_ff_vld <= 1'b1;
                            r_ff_vec <= r_vec;
                        end
                        if (w_end_run) begin
                            r_state  <= ST_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_pass   <= (w_err_next == '0);
                            r_dut_in <= '0;
                        end else begin
                            r_vec    <= w_vec_next;
                            r_dut_in <= w_vec_next;
                            r_settle <= '0;
                            if (r_vec == VEC_LAST) begin
                                r_sweep <= r_sweep + CNT_W'(1);
                            end
                        end
                    end else begin
                        r_settle <= r_settle + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_done   <= 1'b0;
                    r_dut_in <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_sweep.busy           = r_busy;
    assign io_sweep.done           = r_done;
    assign io_sweep.pass           = r_pass;
    assign io_sweep.dut_in         = r_dut_in;
    assign io_sweep.err_cnt        = r_err_cnt;
    assign io_sweep.first_fail_vld = r_ff_vld;
    assign io_sweep.first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: two instances (SETTLE=1/REPEAT=1 and
// SETTLE=0/REPEAT=3) each driving a modelled AND/OR datapath with optional
// stuck-at faults. Expectations follow GATE_SWEEP_STOP_ON_FAIL_EN if defined.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert (32'(obs) === 32'(exp)) else begin \
            errors++; \
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
        end \
    end

module tb_gate_sweep_ctrl;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       sel_b;
    logic [1:0] fault;     // 0 none, 1 out1 stuck-at-1, 2 out2 stuck-at-0

    int checks = 0;
    int errors = 0;

    int busy_n, first_busy, last_busy, done_n, done_at, din_bad;

    gate_sweep_ctrl_if if_a ();
    gate_sweep_ctrl_if if_b ();

    gate_sweep_ctrl #(.SETTLE_CYCLES(1), .REPEAT(1)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .io_sweep (if_a)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(0), .REPEAT(3)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .io_sweep (if_b)
    );

    // Datapath models with fault injection
    assign if_a.dut_out1 = (fault == 2'd1) ? 1'b1 : &if_a.dut_in;
    assign if_a.dut_out2 = (fault == 2'd2) ? 1'b0 : |if_a.dut_in;
    assign if_b.dut_out1 = (fault == 2'd1) ? 1'b1 : &if_b.dut_in;
    assign if_b.dut_out2 = (fault == 2'd2) ? 1'b0 : |if_b.dut_in;

    assign if_a.start = start && !sel_b;
    assign if_b.start = start && sel_b;

    logic       w_busy, w_done, w_pass, w_ffv;
    logic [2:0] w_din, w_ffvec;
    logic [7:0] w_err;

    assign w_busy  = sel_b ? if_b.busy           : if_a.busy;
    assign w_done  = sel_b ? if_b.done           : if_a.done;
    assign w_pass  = sel_b ? if_b.pass           : if_a.pass;
    assign w_din   = sel_b ? if_b.dut_in         : if_a.dut_in;
    assign w_err   = sel_b ? if_b.err_cnt        : if_a.err_cnt;
    assign w_ffv   = sel_b ? if_b.first_fail_vld : if_a.first_fail_vld;
    assign w_ffvec = sel_b ? if_b.first_fail_vec : if_a.first_fail_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start on the selected instance, then observe cycles 1..win after
    // the accept edge; start is re-driven high in cycles re1/re2.
    task automatic run_win(input int win, input int spv, input int re1, input int re2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_n = 0; first_busy = -1; last_busy = -1;
        done_n = 0; done_at = -1; din_bad = 0;
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            if (w_busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
                if (w_din !== 3'((c - 1) / spv)) din_bad++;
            end else if (w_din !== 3'b000) begin
                din_bad++;
            end
            if (w_done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            start = (c == re1) || (c == re2);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel_b = 1'b0;
        fault = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        `CHK("rst_busy",    w_busy,  0)
        `CHK("rst_done",    w_done,  0)
        `CHK("rst_pass",    w_pass,  0)
        `CHK("rst_dut_in",  w_din,   0)
        `CHK("rst_err_cnt", w_err,   0)
        `CHK("rst_ff_vld",  w_ffv,   0)
        `CHK("rst_ff_vec",  w_ffvec, 0)
        `CHK("rst_b_busy",  if_b.busy, 0)
        rst = 1'b0;

        // Fault-free run, SETTLE=1 REPEAT=1: N=16
        run_win(20, 2, 0, 0);
        `CHK("ok_busy_n",    busy_n,     16)
        `CHK("ok_first_bsy", first_busy, 1)
        `CHK("ok_last_bsy",  last_busy,  16)
        `CHK("ok_done_n",    done_n,     1)
        `CHK("ok_done_at",   done_at,    17)
        `CHK("ok_dut_in",    din_bad,    0)
        `CHK("ok_pass",      w_pass,     1)
        `CHK("ok_err",       w_err,      0)
        `CHK("ok_ff_vld",    w_ffv,      0)

        // out1 stuck-at-1: vectors 0..6 mismatch
        fault = 2'd1;
        run_win(20, 2, 0, 0);
        `CHK("s1_done_n",  done_n,  1)
        `CHK("s1_done_at", done_at, STOP ? 3 : 17)
        `CHK("s1_busy_n",  busy_n,  STOP ? 2 : 16)
        `CHK("s1_dut_in",  din_bad, 0)
        `CHK("s1_err",     w_err,   STOP ? 1 : 7)
        `CHK("s1_ff_vld",  w_ffv,   1)
        `CHK("s1_ff_vec",  w_ffvec, 0)
        `CHK("s1_pass",    w_pass,  0)

        // Same fault on SETTLE=0 REPEAT=3: N=24
        sel_b = 1'b1;
        run_win(28, 1, 0, 0);
        `CHK("s1b_done_n",  done_n,  1)
        `CHK("s1b_done_at", done_at, STOP ? 2 : 25)
        `CHK("s1b_busy_n",  busy_n,  STOP ? 1 : 24)
        `CHK("s1b_dut_in",  din_bad, 0)
        `CHK("s1b_err",     w_err,   STOP ? 1 : 21)
        `CHK("s1b_ff_vec",  w_ffvec, 0)
        `CHK("s1b_pass",    w_pass,  0)
        sel_b = 1'b0;

        // out2 stuck-at-0: vectors 1..7 mismatch
        fault = 2'd2;
        run_win(20, 2, 0, 0);
        `CHK("s0_done_at", done_at, STOP ? 5 : 17)
        `CHK("s0_busy_n",  busy_n,  STOP ? 4 : 16)
        `CHK("s0_err",     w_err,   STOP ? 1 : 7)
        `CHK("s0_ff_vld",  w_ffv,   1)
        `CHK("s0_ff_vec",  w_ffvec, 1)
        `CHK("s0_pass",    w_pass,  0)

        // start re-asserted in RUN (cycle 5) and DONE (cycle 17) is ignored
        fault = 2'd0;
        run_win(17, 2, 5, 17);
        `CHK("rs_busy_n",  busy_n,  16)
        `CHK("rs_done_n",  done_n,  1)
        `CHK("rs_done_at", done_at, 17)
        `CHK("rs_ff_vld",  w_ffv,   0)
        // Back-to-back start in cycle N+2 is accepted
        run_win(20, 2, 0, 0);
        `CHK("bb_first_bsy", first_busy, 1)
        `CHK("bb_busy_n",    busy_n,     16)
        `CHK("bb_done_at",   done_at,    17)
        `CHK("bb_done_n",    done_n,     1)
        `CHK("bb_pass",      w_pass,     1)

        // Reset in cycle 6 of a run aborts it silently
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        `CHK("mr_busy_c6",   w_busy, 1)
        `CHK("mr_dut_in_c6", w_din,  2)
        rst = 1'b1;
        @(negedge clk);
        `CHK("mr_busy",    w_busy,  0)
        `CHK("mr_done",    w_done,  0)
        `CHK("mr_pass",    w_pass,  0)
        `CHK("mr_dut_in",  w_din,   0)
        `CHK("mr_err",     w_err,   0)
        `CHK("mr_ff_vld",  w_ffv,   0)
        `CHK("mr_ff_vec",  w_ffvec, 0)
        rst = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (w_done) done_n++;
            if (w_busy) busy_n++;
        end
        `CHK("mr_no_done", done_n, 0)
        `CHK("mr_no_busy", busy_n, 0)

        // Full fault-free run after the aborted one
        run_win(20, 2, 0, 0);
        `CHK("ar_busy_n",  busy_n,  16)
        `CHK("ar_done_at", done_at, 17)
        `CHK("ar_dut_in",  din_bad, 0)
        `CHK("ar_pass",    w_pass,  1)
        `CHK("ar_err",     w_err,   0)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`undef CHK

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sweep controller for the three-input AND/OR gate datapath. It takes over the datapath inputs and applies all eight input vectors, repeating the sweep a set number of times. On each vector it waits a configurable settle time, then compares both datapath outputs against the expected AND/OR values. It counts mismatches and reports pass/fail with a start/done handshake, replacing the free-running counter stimulus in the top-level bench.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: extra cycles each vector is held before sampling; legal range 0..15.
- REPEAT, default 1: number of full 8-vector sweeps per run; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; run finished.
- pass  out  1  high when the last run had zero mismatches; valid from done until the next start.
- dut_in  out  3  drives datapath in_1/in_2/in_3 on bits [0]/[1]/[2].
- dut_out1  in  1  datapath AND output.
- dut_out2  in  1  datapath OR output.
- err_cnt  out  8  mismatch count for the current/last run; saturates at 255.
- first_fail_vld  out  1  at least one mismatch has occurred in the current/last run.
- first_fail_vec  out  3  vector of the first mismatch; valid when first_fail_vld=1.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN: on start=1. Clears err_cnt, first_fail_vld, first_fail_vec and pass; vec=0, sweep=0, settle=0.
  - RUN → DONE: after the compare of vector 7 in the last sweep (sweep=REPEAT-1).
  - DONE → IDLE: unconditionally after one cycle.
- RUN behaviour:
  - dut_in = vec, registered.
  - The settle counter counts 0..SETTLE_CYCLES. On the cycle where settle==SETTLE_CYCLES, the block samples dut_out1 and dut_out2 and compares them.
  - Expected values: exp1 = &vec, exp2 = |vec.
  - A mismatch exists if dut_out1≠exp1 or dut_out2≠exp2. Both outputs wrong on the same vector counts as one mismatch.
  - On a mismatch: err_cnt increments, saturating at 255. If first_fail_vld=0, first_fail_vec is set to vec and first_fail_vld to 1.
  - After each compare: vec increments and wraps 7→0; on the wrap, sweep increments; settle returns to 0.
- DONE: done=1 and pass=(err_cnt==0 after the final compare). pass holds through IDLE until the next accepted start.
- dut_in=3'b000 in IDLE and DONE.
- start in RUN or DONE is ignored; a request is not queued.
- rst in any state: returns to IDLE on the next edge, mid-sweep included. No done pulse is generated.
- Reset values: busy=0, done=0, pass=0, dut_in=0, err_cnt=0, first_fail_vld=0, first_fail_vec=0.

## Timing
- Start accept edge = edge E0, where start=1 in IDLE. The cycle after E0 is RUN with dut_in=0 and busy=1.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- Outputs are sampled at the last edge of the vector, so the datapath sees a stable input for SETTLE_CYCLES+1 cycles.
- Let N = 8·(SETTLE_CYCLES+1)·REPEAT. busy is high for cycles 1..N after E0; done is high in cycle N+1; IDLE from cycle N+2.
- A new start is accepted at the earliest in cycle N+2, so back-to-back runs are possible.
- err_cnt and first_fail_* update on the edge of the compare and are visible the following cycle.

## Configuration
- GATE_SWEEP_STOP_ON_FAIL_EN defined:
  - The first mismatch ends the run: RUN → DONE on the compare edge, with err_cnt=1 and pass=0.
  - done fires (SETTLE_CYCLES+1)·(k+1)+1 cycles after E0, where k is the global index of the failing vector.
- Not defined: the full N-cycle run always executes and all mismatches are counted.

## Test plan
- Fault-free datapath, SETTLE_CYCLES=1, REPEAT=1, start pulse → busy for 16 cycles, done in cycle 17, pass=1, err_cnt=0, first_fail_vld=0.
- dut_out1 stuck at 1, macro off → err_cnt=7 (vectors 0..6), first_fail_vec=0, pass=0. With REPEAT=3 → err_cnt=21.
- dut_out2 stuck at 0, macro off → err_cnt=7, first_fail_vec=1.
- Same fault, macro on, SETTLE_CYCLES=1 → done in cycle 5, err_cnt=1, first_fail_vec=1.
- start re-asserted during RUN and during DONE → ignored: exactly one done pulse, cycle count unchanged. Then a new start in cycle N+2 → accepted.
- rst asserted at cycle 6 of a run → next cycle IDLE, all outputs at reset values, no done pulse. A subsequent start gives a full fault-free run with pass=1.
